rx_gate_averager: RTL and testbench

- Sits between the ADC receiver input (RX/RX_OTR, sampled on RX_CLK strobes) and the Storeage FIFO write port.
- During the demodulation window (DEMOD_ON from CoreLayer), accumulates blocks of 2^k ADC samples and emits one arithmetic-mean 16-bit result per block.
- Presents each result to the FIFO through a single-entry valid/ready output register.
- Reduces FIFO fill rate and reports overrange and dropped-result conditions.

---
 rtl/rx_gate_averager_pkg.sv | 36 +++
 rtl/rx_gate_averager_conditioner.sv | 22 ++
 rtl/rx_gate_averager.sv | 145 ++++++++++++++
 tb/tb_rx_gate_averager.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_gate_averager_pkg.sv
// Shared widths, state encoding and helpers for the gated ADC block averager.
package rx_gate_averager_pkg;

  localparam int unsigned DATA_W    = 14;
  localparam int unsigned OUT_W     = 16;
  localparam int unsigned MAX_SHIFT = 7;
  localparam int unsigned DROP_W    = 8;
  localparam int unsigned SHIFT_W   = 3;
  localparam int unsigned AVG_ACC_W = DATA_W + MAX_SHIFT;
  localparam int unsigned CNT_W     = MAX_SHIFT;

  localparam logic [DATA_W-1:0] ADC_POS_CLAMP = 14'h1FFF;
  localparam logic [DATA_W-1:0] ADC_NEG_CLAMP = 14'h2000;

  typedef enum logic [1:0] {
    AVG_IDLE  = 2'd0,
    AVG_ACCUM = 2'd1,
    AVG_FLUSH = 2'd2
  } avg_state_e;

  typedef struct packed {
    logic             valid;
    logic [OUT_W-1:0] data;
  } avg_result_t;

  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
    if (32'(s) > MAX_SHIFT) return SHIFT_W'(MAX_SHIFT);
    return s;
  endfunction

  // Sample index that closes a block of 2^k samples.
  function automatic logic [CNT_W-1:0] block_last(input logic [SHIFT_W-1:0] k);
    return CNT_W'((32'd1 << k) - 32'd1);
  endfunction

endpackage

// File: rtl/rx_gate_averager_conditioner.sv
// Combinational ADC out-of-range clamp and sign-extension to accumulator width.
module rx_sample_conditioner
  import rx_gate_averager_pkg::*;
(
  input  logic [DATA_W-1:0]           rx_i,
  input  logic                        otr_i,
  output logic signed [AVG_ACC_W-1:0] sample_c_o,
  output logic                        ovr_c_o
);

  logic [DATA_W-1:0] clamped;

  // Out-of-range samples saturate toward the rail indicated by the sign bit.
  always_comb begin
    clamped = rx_i;
    if (otr_i) clamped = rx_i[DATA_W-1] ? ADC_NEG_CLAMP : ADC_POS_CLAMP;
  end

  assign sample_c_o = AVG_ACC_W'($signed(clamped));
  assign ovr_c_o    = otr_i;

endmodule

// File: rtl/rx_gate_averager.sv
// Windowed block averager between the ADC receiver and the storage FIFO write port.
module rx_gate_averager
  import rx_gate_averager_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic                SAMPLE_EN,
  input  logic                GATE,
  input  logic [DATA_W-1:0]   RX,
  input  logic                RX_OTR,
  input  logic [SHIFT_W-1:0]  AVG_SHIFT,
  input  logic                READY,
  output logic [OUT_W-1:0]    DOUT,
  output logic                DOUT_VALID,
  output logic                GATE_DONE,
  output logic                OVERRANGE,
  output logic [DROP_W-1:0]   DROP_CNT
);

  avg_state_e                  state_q, state_d;
  logic                        gate_q;
  logic [SHIFT_W-1:0]          k_q, k_d;
  logic signed [AVG_ACC_W-1:0] acc_q, acc_d, acc_base, sum_c, sample_c;
  logic [CNT_W-1:0]            cnt_q, cnt_d, cnt_base;
  logic [OUT_W-1:0]            dout_q, dout_d;
  logic                        dout_valid_q, dout_valid_d;
  logic                        gate_done_q, gate_done_d;
  logic                        ovr_q, ovr_d, ovr_c;
  logic [DROP_W-1:0]           drop_q, drop_d;
  logic                        accept_c;
  avg_result_t                 res_c;

  rx_sample_conditioner u_cond (
    .rx_i       (RX),
    .otr_i      (RX_OTR),
    .sample_c_o (sample_c),
    .ovr_c_o    (ovr_c)
  );

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    ovr_d        = ovr_q;
    acc_base     = acc_q;
    cnt_base     = cnt_q;
    accept_c     = 1'b0;
    sum_c        = '0;
    res_c        = '0;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    drop_d       = drop_q;

    case (state_q)
      AVG_IDLE: begin
        // Window opens: fresh block, and a strobe in this cycle counts as its first sample.
        if (GATE && !gate_q) begin
          state_d  = AVG_ACCUM;
          k_d      = clamp_shift(AVG_SHIFT);
          acc_base = '0;
          cnt_base = '0;
          acc_d    = '0;
          cnt_d    = '0;
          ovr_d    = 1'b0;
          accept_c = SAMPLE_EN;
        end
      end
      AVG_ACCUM: begin
        // Window close wins over a completing strobe; the partial block is discarded.
        if (!GATE) begin
          state_d = AVG_FLUSH;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          accept_c = SAMPLE_EN;
        end
      end
      AVG_FLUSH: state_d = AVG_IDLE;
      default:   state_d = AVG_IDLE;
    endcase

    sum_c = acc_base + sample_c;
    if (accept_c) begin
      if (ovr_c) ovr_d = 1'b1;
      if (cnt_base == block_last(k_d)) begin
        res_c.valid = 1'b1;
        res_c.data  = OUT_W'(sum_c >>> k_d);
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = sum_c;
        cnt_d = cnt_base + CNT_W'(1);
      end
    end

    // Single-entry output register: a full, stalled register drops the newcomer.
    if (res_c.valid) begin
      if (!dout_valid_q || READY) begin
        dout_d       = res_c.data;
        dout_valid_d = 1'b1;
      end else if (drop_q != '1) begin
        drop_d = drop_q + DROP_W'(1);
      end
    end else if (dout_valid_q && READY) begin
      dout_valid_d = 1'b0;
    end

    gate_done_d = (state_d == AVG_FLUSH);
  end

  // Reset samples GATE so a level held through reset is not taken as a new window.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= AVG_IDLE;
      gate_q       <= GATE;
      k_q          <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      gate_done_q  <= 1'b0;
      ovr_q        <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      gate_q       <= GATE;
      k_q          <= k_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      gate_done_q  <= gate_done_d;
      ovr_q        <= ovr_d;
      drop_q       <= drop_d;
    end
  end

  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_valid_q;
  assign GATE_DONE  = gate_done_q;
  assign OVERRANGE  = ovr_q;
  assign DROP_CNT   = drop_q;

endmodule

// File: tb/tb_rx_gate_averager.sv
// Directed and randomized bench for rx_gate_averager against a queue-based block-mean model.
module tb_rx_gate_averager;

  logic        clk;
  logic        rst;
  logic        sample_en;
  logic        gate;
  logic [13:0] rx;
  logic        rx_otr;
  logic [2:0]  avg_shift;
  logic        ready;
  logic [15:0] dout;
  logic        dout_valid;
  logic        gate_done;
  logic        overrange;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: window flags plus the raw samples of the open block.
  bit          m_active, m_flush, m_prev_gate;
  int          m_k;
  int          m_blk[$];
  logic [15:0] m_dout;
  bit          m_valid, m_gdone, m_ovr;
  int          m_drop;

  rx_gate_averager dut (
    .CLK        (clk),
    .RESET      (rst),
    .SAMPLE_EN  (sample_en),
    .GATE       (gate),
    .RX         (rx),
    .RX_OTR     (rx_otr),
    .AVG_SHIFT  (avg_shift),
    .READY      (ready),
    .DOUT       (dout),
    .DOUT_VALID (dout_valid),
    .GATE_DONE  (gate_done),
    .OVERRANGE  (overrange),
    .DROP_CNT   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit          take;
    bit          have;
    int          v, s, n, q;
    logic [15:0] res;
    take = 1'b0;
    have = 1'b0;
    res  = '0;
    if (rst) begin
      m_active = 0; m_flush = 0; m_blk.delete();
      m_dout = '0; m_valid = 0; m_gdone = 0; m_ovr = 0; m_drop = 0;
      m_prev_gate = gate;
      return;
    end
    if (m_flush) begin
      m_flush = 0;
    end else if (!m_active) begin
      if (gate && !m_prev_gate) begin
        m_active = 1;
        m_k      = int'(avg_shift);
        m_blk.delete();
        m_ovr    = 0;
        take     = sample_en;
      end
    end else if (!gate) begin
      m_active = 0;
      m_flush  = 1;
      m_blk.delete();
    end else begin
      take = sample_en;
    end
    if (take) begin
      if (rx_otr) begin
        m_ovr = 1;
        v = rx[13] ? -8192 : 8191;
      end else begin
        v = int'($signed(rx));
      end
      m_blk.push_back(v);
      n = 1 << m_k;
      if (m_blk.size() == n) begin
        s = 0;
        foreach (m_blk[i]) s += m_blk[i];
        q = s / n;
        if ((s % n) != 0 && s < 0) q = q - 1;
        res  = 16'(q);
        have = 1'b1;
        m_blk.delete();
      end
    end
    if (have) begin
      if (!m_valid || ready) begin
        m_dout  = res;
        m_valid = 1;
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end else if (m_valid && ready) begin
      m_valid = 0;
    end
    m_gdone     = m_flush;
    m_prev_gate = gate;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk_eq("dout",       32'(dout),       32'(m_dout));
    chk_eq("dout_valid", 32'(dout_valid), 32'(m_valid));
    chk_eq("gate_done",  32'(gate_done),  32'(m_gdone));
    chk_eq("overrange",  32'(overrange),  32'(m_ovr));
    chk_eq("drop_cnt",   32'(drop_cnt),   32'(m_drop));
  endtask

  task automatic send(input logic [13:0] v, input logic o);
    sample_en = 1'b1;
    rx        = v;
    rx_otr    = o;
    tick();
    sample_en = 1'b0;
    rx_otr    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b0; gate = 1'b0; rx = '0; rx_otr = 1'b0;
    avg_shift = 3'd0; ready = 1'b1;
    tick(); tick();
    chk_eq("reset_dout",  32'(dout),       32'h0);
    chk_eq("reset_valid", 32'(dout_valid), 32'h0);
    rst = 1'b0;
    tick();

    // k=2 block means of 10 and -4
    avg_shift = 3'd2; gate = 1'b1; tick();
    send(14'd4, 0); send(14'd8, 0); send(14'd12, 0);
    send(14'd16, 0);
    chk_eq("t1_res0", 32'(dout), 32'h000A);
    chk_eq("t1_val0", 32'(dout_valid), 32'h1);
    send(14'h3FFC, 0); send(14'h3FFC, 0); send(14'h3FFC, 0);
    send(14'h3FFC, 0);
    chk_eq("t1_res1", 32'(dout), 32'hFFFC);
    gate = 1'b0; tick();
    chk_eq("t1_gdone", 32'(gate_done), 32'h1);
    tick();
    chk_eq("t1_gdone_end", 32'(gate_done), 32'h0);

    // k=0 pass-through and OTR clamp
    avg_shift = 3'd0; gate = 1'b1; tick();
    send(14'h2000, 0);
    chk_eq("t2_neg", 32'(dout), 32'hE000);
    send(14'h0005, 1);
    chk_eq("t2_clamp", 32'(dout), 32'h1FFF);
    chk_eq("t2_ovr", 32'(overrange), 32'h1);
    gate = 1'b0; tick(); tick(); tick();
    chk_eq("t2_ovr_sticky", 32'(overrange), 32'h1);
    gate = 1'b1; tick();
    chk_eq("t2_ovr_clear", 32'(overrange), 32'h0);
    gate = 1'b0; tick(); tick(); tick();

    // k=1 with FIFO stalled: hold first result, drop the rest
    avg_shift = 3'd1; ready = 1'b0; gate = 1'b1; tick();
    for (int i = 1; i <= 6; i++) send(14'(10 * i), 0);
    chk_eq("t3_hold", 32'(dout), 32'h000F);
    chk_eq("t3_drop", 32'(drop_cnt), 32'd2);
    ready = 1'b1; tick();
    chk_eq("t3_release", 32'(dout_valid), 32'h0);
    gate = 1'b0; tick(); tick(); tick();

    // k=3 window aborted after 5 samples, next window starts clean
    avg_shift = 3'd3; gate = 1'b1; tick();
    for (int i = 0; i < 5; i++) send(14'd100, 0);
    gate = 1'b0; tick();
    chk_eq("t4_gdone", 32'(gate_done), 32'h1);
    tick();
    chk_eq("t4_gdone_once", 32'(gate_done), 32'h0);
    chk_eq("t4_noout", 32'(dout_valid), 32'h0);
    tick();
    gate = 1'b1; tick();
    for (int i = 0; i < 8; i++) send(14'd8, 0);
    chk_eq("t4_fresh", 32'(dout), 32'h0008);
    gate = 1'b0; tick(); tick(); tick();

    // reset mid-window with a held word and DROP_CNT=3
    avg_shift = 3'd0; ready = 1'b0; gate = 1'b1; tick();
    send(14'd1, 0); send(14'd2, 0);
    chk_eq("t5_pre_drop", 32'(drop_cnt), 32'd3);
    rst = 1'b1; tick();
    chk_eq("t5_dout", 32'(dout), 32'h0);
    chk_eq("t5_valid", 32'(dout_valid), 32'h0);
    chk_eq("t5_drop", 32'(drop_cnt), 32'h0);
    rst = 1'b0; ready = 1'b1; tick();
    for (int i = 0; i < 3; i++) send(14'd7, 0);
    chk_eq("t5_idle", 32'(dout_valid), 32'h0);
    gate = 1'b0; tick(); tick();

    // k=1 floor rounding: (-1 + -2) >>> 1 = -2
    avg_shift = 3'd1; gate = 1'b1; tick();
    send(14'h3FFF, 0); send(14'h3FFE, 0);
    chk_eq("t6_floor", 32'(dout), 32'hFFFE);
    gate = 1'b0; tick(); tick(); tick();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 29) == 0) gate = ~gate;
      sample_en = $urandom_range(0, 1) == 1;
      rx        = 14'($urandom);
      rx_otr    = ($urandom_range(0, 15) == 0);
      avg_shift = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      ready     = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
